// File: rtl/operand_fetch_if.sv
// Decode-to-EX handshake bundle for the operand fetch stage.
// The stage itself uses the slave modport; the decode/EX environment uses master.
interface operand_fetch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic            in_is_load;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_is_load;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_is_load, in_pc, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_pc, out_rd, out_is_load
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_is_load, in_pc, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_pc, out_rd, out_is_load
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: issues RF reads, resolves EX/MEM RAW hazards, hands operands to EX.
// Define OPERAND_FWD_EN for forwarding with load-use stalls; otherwise any EX/MEM match stalls.
module operand_fetch_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    operand_fetch_if.slave  bus,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_out1,
    input  logic [XLEN-1:0] rf_out2,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    output logic            hazard_stall
);

    typedef enum logic [1:0] {IDLE, READ, STALL, VALID} state_t;

    state_t          state;
    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic [4:0]      rd_p0;
    logic            is_load_p0;
    logic [XLEN-1:0] pc_p0;

    logic            accept;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic            stall_req;
    logic [XLEN-1:0] op1_sel, op2_sel;

    assign bus.in_ready = !rst && !flush &&
                          ((state == IDLE) || ((state == VALID) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Re-issuing the latched indices keeps rf_out pointing at the held instruction.
    assign rf_rs1 = bus.in_ready ? bus.in_rs1 : rs1_p0;
    assign rf_rs2 = bus.in_ready ? bus.in_rs2 : rs2_p0;

    assign ex_hit1  = (rs1_p0 != 5'd0) && ex_we  && (ex_rd  == rs1_p0);
    assign ex_hit2  = (rs2_p0 != 5'd0) && ex_we  && (ex_rd  == rs2_p0);
    assign mem_hit1 = (rs1_p0 != 5'd0) && mem_we && (mem_rd == rs1_p0);
    assign mem_hit2 = (rs2_p0 != 5'd0) && mem_we && (mem_rd == rs2_p0);

`ifdef OPERAND_FWD_EN
    assign stall_req = ex_is_load && (ex_hit1 || ex_hit2);
    assign op1_sel   = ex_hit1 ? ex_result : (mem_hit1 ? mem_result : rf_out1);
    assign op2_sel   = ex_hit2 ? ex_result : (mem_hit2 ? mem_result : rf_out2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_result, mem_result};
    assign stall_req  = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    assign op1_sel    = rf_out1;
    assign op2_sel    = rf_out2;
`endif

    // Stage p0: instruction fields held from accept until the next accept
    always_ff @(posedge clk) begin
        if (accept) begin
            rs1_p0     <= bus.in_rs1;
            rs2_p0     <= bus.in_rs2;
            rd_p0      <= bus.in_rd;
            is_load_p0 <= bus.in_is_load;
            pc_p0      <= bus.in_pc;
        end
    end

    // Stage p1: control FSM with registered operand outputs to EX
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.out_valid   <= 1'b0;
            bus.out_op1     <= '0;
            bus.out_op2     <= '0;
            bus.out_pc      <= '0;
            bus.out_rd      <= '0;
            bus.out_is_load <= 1'b0;
            hazard_stall    <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            hazard_stall  <= 1'b0;
        end else begin
            hazard_stall <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) state <= READ;
                end
                READ: begin
                    if (stall_req) begin
                        state        <= STALL;
                        hazard_stall <= 1'b1;
                    end else begin
                        state           <= VALID;
                        bus.out_valid   <= 1'b1;
                        bus.out_op1     <= op1_sel;
                        bus.out_op2     <= op2_sel;
                        bus.out_pc      <= pc_p0;
                        bus.out_rd      <= rd_p0;
                        bus.out_is_load <= is_load_p0;
                    end
                end
                STALL: state <= READ;
                VALID: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= accept ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow whether OPERAND_FWD_EN is defined.
module tb_operand_fetch_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [4:0]      rf_rs1, rf_rs2;
    logic [XLEN-1:0] rf_out1, rf_out2;
    logic            ex_we, ex_is_load, mem_we;
    logic [4:0]      ex_rd, mem_rd;
    logic [XLEN-1:0] ex_result, mem_result;
    logic            hazard_stall;
    logic [XLEN-1:0] regs [32];

    int n_checks = 0;
    int n_errors = 0;
    int lat, stalls;

    operand_fetch_if #(.XLEN(XLEN)) bus ();

    operand_fetch_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // Register file with registered read ports; x0 reads zero
    always @(posedge clk) begin
        rf_out1 <= (rf_rs1 == 5'd0) ? '0 : regs[rf_rs1];
        rf_out2 <= (rf_rs2 == 5'd0) ? '0 : regs[rf_rs2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pipe();
        ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = '0;
        mem_we = 1'b0; mem_rd = 5'd0; mem_result = '0;
    endtask

    // Presents one instruction at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic [31:0] pc, input logic ld);
        bus.in_rs1 = s1; bus.in_rs2 = s2; bus.in_rd = d; bus.in_pc = pc;
        bus.in_is_load = ld; bus.in_valid = 1'b1;
        #1;
        chk("in_ready_at_issue", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_to_valid(output int l, output int s);
        l = 0;
        s = 0;
        for (int i = 2; i < 24; i++) begin
            @(negedge clk);
            if (hazard_stall) s++;
            if (bus.out_valid) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h1000 + r;
        regs[1] = 32'd5; regs[2] = 32'd7; regs[5] = 32'h55;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.in_is_load = 1'b0; bus.in_pc = '0; bus.out_ready = 1'b1;
        clear_pipe();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_op1", bus.out_op1, 32'h0);
        chk("rst_op2", bus.out_op2, 32'h0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_rd", bus.out_rd, 5'd0);
        chk("rst_is_load", bus.out_is_load, 1'b0);
        chk("rst_hazard", hazard_stall, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Plain read, no hazards
        issue(5'd1, 5'd2, 5'd9, 32'h100, 1'b0);
        chk("read_rf_rs1_latched", rf_rs1, 5'd1);
        chk("read_out_valid", bus.out_valid, 1'b0);
        run_to_valid(lat, stalls);
        chk("plain_latency", lat, 2);
        chk("plain_stalls", stalls, 0);
        chk("plain_op1", bus.out_op1, 32'd5);
        chk("plain_op2", bus.out_op2, 32'd7);
        chk("plain_pc", bus.out_pc, 32'h100);
        chk("plain_rd", bus.out_rd, 5'd9);

        // Index 0 never matches EX/MEM, even a load
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; ex_result = 32'hAA;
        mem_we = 1'b1; mem_rd = 5'd0; mem_result = 32'hBB;
        issue(5'd0, 5'd2, 5'd3, 32'h104, 1'b0);
        run_to_valid(lat, stalls);
        chk("x0_latency", lat, 2);
        chk("x0_stalls", stalls, 0);
        chk("x0_op1", bus.out_op1, 32'h0);
        chk("x0_op2", bus.out_op2, 32'd7);
        clear_pipe();

`ifdef OPERAND_FWD_EN
        // EX has priority over MEM
        ex_we = 1'b1; ex_rd = 5'd3; ex_result = 32'hAA;
        mem_we = 1'b1; mem_rd = 5'd3; mem_result = 32'hBB;
        issue(5'd3, 5'd2, 5'd4, 32'h108, 1'b0);
        run_to_valid(lat, stalls);
        chk("fwd_ex_latency", lat, 2);
        chk("fwd_ex_op1", bus.out_op1, 32'hAA);
        chk("fwd_ex_op2", bus.out_op2, 32'd7);

        // MEM-only forward on rs2
        ex_we = 1'b0; mem_rd = 5'd2;
        issue(5'd1, 5'd2, 5'd4, 32'h10C, 1'b0);
        run_to_valid(lat, stalls);
        chk("fwd_mem_op1", bus.out_op1, 32'd5);
        chk("fwd_mem_op2", bus.out_op2, 32'hBB);
        clear_pipe();

        // Load-use on rs2: one stall, then the load result arrives from MEM
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; ex_result = 32'hDEAD;
        issue(5'd1, 5'd4, 5'd6, 32'h110, 1'b0);
        @(negedge clk);
        chk("lu_stall", hazard_stall, 1'b1);
        chk("lu_stall_valid", bus.out_valid, 1'b0);
        clear_pipe();
        mem_we = 1'b1; mem_rd = 5'd4; mem_result = 32'h1234;
        @(negedge clk);
        chk("lu_reread_stall", hazard_stall, 1'b0);
        chk("lu_reread_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lu_valid_n4", bus.out_valid, 1'b1);
        chk("lu_op1", bus.out_op1, 32'd5);
        chk("lu_op2", bus.out_op2, 32'h1234);
        clear_pipe();
`else
        // EX writer held over three READ evaluations: three stall pulses, no forwarding
        ex_we = 1'b1; ex_rd = 5'd5; ex_result = 32'hEE;
        issue(5'd5, 5'd1, 5'd7, 32'h120, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nf_stall_pulse", hazard_stall, 1'b1);
            if (k == 2) ex_we = 1'b0;
            @(negedge clk);
            chk("nf_reread_stall", hazard_stall, 1'b0);
            chk("nf_reread_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        chk("nf_valid", bus.out_valid, 1'b1);
        chk("nf_op1", bus.out_op1, 32'h55);
        chk("nf_op2", bus.out_op2, 32'd5);
        clear_pipe();

        // A MEM writer also stalls without forwarding
        mem_we = 1'b1; mem_rd = 5'd2; mem_result = 32'hBB;
        issue(5'd1, 5'd2, 5'd7, 32'h124, 1'b0);
        @(negedge clk);
        chk("nf_mem_stall", hazard_stall, 1'b1);
        mem_we = 1'b0;
        @(negedge clk);
        chk("nf_mem_reread", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("nf_mem_valid", bus.out_valid, 1'b1);
        chk("nf_mem_op2", bus.out_op2, 32'd7);
        clear_pipe();
`endif

        // Backpressure: outputs hold in VALID, then back-to-back accept
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd10, 32'h200, 1'b0);
        @(negedge clk);
        chk("hold_valid", bus.out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1'b1);
            chk("hold_op1", bus.out_op1, 32'd5);
            chk("hold_op2", bus.out_op2, 32'd7);
            chk("hold_pc", bus.out_pc, 32'h200);
            chk("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        issue(5'd2, 5'd1, 5'd8, 32'h300, 1'b1);
        chk("b2b_read_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("b2b_valid", bus.out_valid, 1'b1);
        chk("b2b_op1", bus.out_op1, 32'd7);
        chk("b2b_op2", bus.out_op2, 32'd5);
        chk("b2b_pc", bus.out_pc, 32'h300);
        chk("b2b_is_load", bus.out_is_load, 1'b1);
        @(negedge clk);

        // Flush during READ, then flush blocking a simultaneous accept
        issue(5'd1, 5'd2, 5'd11, 32'h400, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_idle_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("flush_stays_invalid", bus.out_valid, 1'b0);
        bus.in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_no_accept_a", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("flush_no_accept_b", bus.out_valid, 1'b0);

        // Reset in the middle of a stall
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; ex_result = 32'h77;
        issue(5'd4, 5'd0, 5'd3, 32'h500, 1'b1);
        @(negedge clk);
        chk("rst_stall_entered", hazard_stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("rst_mid_hazard", hazard_stall, 1'b0);
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_op1", bus.out_op1, 32'h0);
        chk("rst_mid_op2", bus.out_op2, 32'h0);
        chk("rst_mid_pc", bus.out_pc, 32'h0);
        chk("rst_mid_rd", bus.out_rd, 5'd0);
        chk("rst_mid_is_load", bus.out_is_load, 1'b0);
        rst = 1'b0;
        clear_pipe();
        #1;
        chk("rst_mid_idle_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-side operand stage that consumes the register file's registered read ports. It issues rs1/rs2 addresses to the register file and collects the read data one cycle later. It resolves RAW hazards against the EX and MEM stages by forwarding, or by stalling on load-use. The resolved operands go to EX through a valid/ready handshake. WB-stage hazards need no handling here, because the register file already forwards same-cycle writes internally.

## Interface
- XLEN, 32, data width
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of the held instruction
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage accepts this cycle
- in_rs1, in_rs2, in_rd  input  5 each  register indices
- in_is_load  input  1  instruction is a load
- in_pc  input  XLEN  instruction PC
- rf_rs1, rf_rs2  output  5 each  register file read addresses
- rf_out1, rf_out2  input  XLEN each  register file data, valid one cycle after its address
- ex_we, ex_is_load  input  1 each  EX-stage writer and load flags
- ex_rd  input  5  EX destination
- ex_result  input  XLEN  EX result
- mem_we  input  1  MEM-stage writer flag
- mem_rd  input  5  MEM destination
- mem_result  input  XLEN  MEM result
- out_valid  output  1  operands valid to EX
- out_ready  input  1  EX accepts
- out_op1, out_op2, out_pc  output  XLEN each  resolved operands and PC
- out_rd  output  5  destination index
- out_is_load  output  1  load flag
- hazard_stall  output  1  high in every STALL cycle

## Operation
- States: IDLE, READ, STALL, VALID. One instruction is held at a time.
- Read address mux: rf_rs1/rf_rs2 = in_rs1/in_rs2 whenever in_ready is high; otherwise the latched indices. Holding the latched indices makes the register file re-read the same registers every cycle.
- in_ready = (IDLE) or (VALID and out_ready). It is forced to 0 while flush or rst is high.
- Accept (in_valid & in_ready):
  - latch rs1, rs2, rd, pc, is_load;
  - next state is READ.
- READ (register file data valid). For each source s, with index 0 never matching:
  - Load-use stall: ex_we & ex_is_load & ex_rd==s → go to STALL; nothing is captured.
  - Otherwise the operand is, in priority order: ex_result if ex_we & ex_rd==s; else mem_result if mem_we & mem_rd==s; else rf_out.
  - Capture both operands and go to VALID.
- STALL: lasts exactly one cycle, then returns to READ. READ re-evaluates against the current EX/MEM state, so the load result is picked up from MEM.
- VALID: out_valid=1 and the captured outputs stay stable.
  - out_ready with a new accept → READ.
  - out_ready without a new accept → IDLE.
  - no out_ready → stay in VALID.
- Operands captured in READ are final. The upstream pipeline guarantees EX/MEM do not advance while out_valid is held without out_ready.
- Source index 0 always reads 0 from the register file and is never forwarded or stalled on.

## Timing
- Reset: state IDLE, out_valid=0, out_op1/op2/pc=0, out_rd=0, out_is_load=0, hazard_stall=0.
- Latency: accept in cycle N → READ in N+1 → out_valid in N+2, with no hazard. Each load-use stall adds 2 cycles.
- Throughput: at most one instruction per 2 cycles.
- flush has priority over everything except rst:
  - next state is IDLE and out_valid drops the next cycle;
  - a simultaneous input transfer is not accepted (in_ready=0).
- rst in any state, including mid-STALL: return to IDLE next cycle with all outputs at their reset values.
- Both sources hazardous: a single stall covers both. Forwarding is evaluated per source independently.

## Configuration
- OPERAND_FWD_EN defined: forwarding and single-cycle load-use stalls as described above.
- OPERAND_FWD_EN undefined:
  - no forwarding; operands always come from rf_out;
  - any match on (ex_we & ex_rd==s) or (mem_we & mem_rd==s) with s≠0 sends READ to STALL;
  - READ↔STALL repeats until no match remains.

## Test plan
- Reset, then accept rs1=1, rs2=2 with RF x1=5, x2=7 and no hazards → out_valid in cycle N+2, op1=5, op2=7, hazard_stall never high.
- ex_we=1, ex_rd=3, ex_result=0xAA; mem_we=1, mem_rd=3, mem_result=0xBB; rs1=3 (FWD_EN) → op1=0xAA (EX priority). Repeat with rs1=0 → op1=0.
- ex load to x4 with rs2=4; next cycle mem_rd=4, mem_result=0x1234 → one hazard_stall cycle, op2=0x1234, out_valid at N+4.
- Hold out_ready=0 for 3 cycles in VALID → outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 → new instruction accepted in the same cycle.
- flush asserted during READ → IDLE next cycle, out_valid stays 0. rst asserted during STALL → all outputs zero next cycle.
- Without OPERAND_FWD_EN: ex_we, ex_rd=5 held 3 cycles with rs1=5 → repeated READ/STALL cycling (3 hazard_stall pulses), then op1 = the register file value.
